// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Purpose: encodings and helpers; no logic of its own.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [3:0] CAUSE_NONE             = 4'd0;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

    // func3[1:0] is the log2 of the access size in bytes
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return offset[0];
            2'b10:   return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed bytes from a cache doubleword and sign/zero-extends them.
// Latency: combinational. Backpressure: none.
// Backpressure: not applicable, pure datapath.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  func3,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (func3)
            LB:      data = {{56{shifted[7]}},  shifted[7:0]};
            LH:      data = {{48{shifted[15]}}, shifted[15:0]};
            LW:      data = {{32{shifted[31]}}, shifted[31:0]};
            LD:      data = shifted;
            LBU:     data = {56'd0, shifted[7:0]};
            LHU:     data = {48'd0, shifted[15:0]};
            LWU:     data = {32'd0, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: issues cache load/store requests and holds the MEM/WB register.
// Latency: 1 cycle for non-memory ops, >= 3 cycles for aligned memory ops.
// Backpressure: o_stall_mem freezes upstream stages until the cache responds.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0] i_pc_target_addr,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [DATA_WIDTH-1:0] i_imm_ext,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [2:0]            i_result_src,
    input  logic [2:0]            i_func3,
    input  logic                  i_mem_re,
    input  logic                  i_mem_we,
    input  logic                  i_reg_we,
    input  logic                  i_ecall_instr,
    output logic                  o_stall_mem,
    output logic                  o_dc_req_valid,
    input  logic                  i_dc_req_ready,
    output logic [ADDR_WIDTH-1:0] o_dc_addr,
    output logic                  o_dc_we,
    output logic [DATA_WIDTH-1:0] o_dc_wdata,
    output logic [7:0]            o_dc_be,
    input  logic                  i_dc_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_dc_rdata,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [ADDR_WIDTH-1:0] o_pc_target_addr,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic [DATA_WIDTH-1:0] o_imm_ext,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [2:0]            o_result_src,
    output logic                  o_reg_we,
    output logic                  o_ecall_instr,
    output logic [3:0]            o_cause
);

    state_e                state;
    logic [2:0]            offset;
    logic                  mem_op;
    logic                  misaligned;
    logic                  aligned_op;
    logic                  resp_take;
    logic [DATA_WIDTH-1:0] load_data;

    assign offset     = i_alu_result[2:0];
    assign mem_op     = i_valid & (i_mem_re | i_mem_we);
    assign misaligned = mem_op & is_misaligned(i_func3[1:0], offset);
    assign aligned_op = mem_op & ~misaligned;
    assign resp_take  = (state == WAIT) & i_dc_resp_valid;

    assign o_stall_mem = ((state == IDLE) & aligned_op)
                       | (state == REQ)
                       | ((state == WAIT) & ~i_dc_resp_valid);

    load_align u_load_align (
        .rdata  (i_dc_rdata),
        .offset (offset),
        .func3  (i_func3),
        .data   (load_data)
    );

    // Request fields are captured once on leaving IDLE so they stay stable in REQ
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_dc_req_valid <= 1'b0;
            o_dc_addr      <= '0;
            o_dc_we        <= 1'b0;
            o_dc_wdata     <= '0;
            o_dc_be        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aligned_op) begin
                        state          <= REQ;
                        o_dc_req_valid <= 1'b1;
                        o_dc_addr      <= {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
                        o_dc_we        <= i_mem_we;
                        o_dc_wdata     <= i_mem_we ? (i_write_data << {offset, 3'b000}) : '0;
                        o_dc_be        <= size_mask(i_func3[1:0]) << offset;
                    end
                end
                REQ: begin
                    if (i_dc_req_ready) begin
                        state          <= WAIT;
                        o_dc_req_valid <= 1'b0;
                        o_dc_addr      <= '0;
                        o_dc_we        <= 1'b0;
                        o_dc_wdata     <= '0;
                        o_dc_be        <= '0;
                    end
                end
                WAIT: begin
                    if (i_dc_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A stalled or empty slot becomes a bubble so WB never repeats a write or ecall
    always_ff @(posedge i_clk) begin
        if (i_rst || o_stall_mem || !i_valid) begin
            o_pc_plus4       <= '0;
            o_pc_target_addr <= '0;
            o_alu_result     <= '0;
            o_read_data      <= '0;
            o_imm_ext        <= '0;
            o_rd_addr        <= '0;
            o_result_src     <= '0;
            o_reg_we         <= 1'b0;
            o_ecall_instr    <= 1'b0;
            o_cause          <= CAUSE_NONE;
        end else begin
            o_pc_plus4       <= i_pc_plus4;
            o_pc_target_addr <= i_pc_target_addr;
            o_alu_result     <= i_alu_result;
            o_read_data      <= (resp_take & i_mem_re) ? load_data : '0;
            o_imm_ext        <= i_imm_ext;
            o_rd_addr        <= i_rd_addr;
            o_result_src     <= i_result_src;
            o_reg_we         <= i_reg_we & ~misaligned;
            o_ecall_instr    <= i_ecall_instr;
            if (misaligned) begin
                o_cause <= i_mem_we ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
            end else begin
                o_cause <= CAUSE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage with a behavioural data cache and a result scoreboard.
module tb_memory_stage;

    typedef struct {
        logic [63:0] pc4, tgt, alu, wd, imm;
        logic [4:0]  rd;
        logic [2:0]  rsrc, f3;
        logic        re, we, rwe, ecall;
    } instr_t;

    typedef struct {
        logic        real_i;
        logic        chk_rdata;
        logic [63:0] pc4, tgt, alu, rdata, imm;
        logic [4:0]  rd;
        logic [2:0]  rsrc;
        logic        rwe, ecall;
        logic [3:0]  cause;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [63:0] i_pc_plus4, i_pc_target_addr, i_alu_result, i_write_data, i_imm_ext;
    logic [4:0]  i_rd_addr;
    logic [2:0]  i_result_src, i_func3;
    logic        i_mem_re, i_mem_we, i_reg_we, i_ecall_instr;
    logic        o_stall_mem, o_dc_req_valid, dc_req_ready, o_dc_we, dc_resp_valid;
    logic [63:0] o_dc_addr, o_dc_wdata, dc_rdata;
    logic [7:0]  o_dc_be;
    logic [63:0] o_pc_plus4, o_pc_target_addr, o_alu_result, o_read_data, o_imm_ext;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_result_src;
    logic        o_reg_we, o_ecall_instr;
    logic [3:0]  o_cause;

    int checks = 0;
    int errors = 0;
    int ecall_cnt = 0;
    exp_t sb[$];

    int          rdy_dly = 0, resp_lat = 0, req_cnt = 0, wait_cnt = 0;
    bit          pend = 0, acc_prev = 0, resp_prev = 0;
    logic [63:0] cache_rdata = '0;

    always #5 clk = ~clk;

    memory_stage dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_valid          (i_valid),
        .i_pc_plus4       (i_pc_plus4),
        .i_pc_target_addr (i_pc_target_addr),
        .i_alu_result     (i_alu_result),
        .i_write_data     (i_write_data),
        .i_imm_ext        (i_imm_ext),
        .i_rd_addr        (i_rd_addr),
        .i_result_src     (i_result_src),
        .i_func3          (i_func3),
        .i_mem_re         (i_mem_re),
        .i_mem_we         (i_mem_we),
        .i_reg_we         (i_reg_we),
        .i_ecall_instr    (i_ecall_instr),
        .o_stall_mem      (o_stall_mem),
        .o_dc_req_valid   (o_dc_req_valid),
        .i_dc_req_ready   (dc_req_ready),
        .o_dc_addr        (o_dc_addr),
        .o_dc_we          (o_dc_we),
        .o_dc_wdata       (o_dc_wdata),
        .o_dc_be          (o_dc_be),
        .i_dc_resp_valid  (dc_resp_valid),
        .i_dc_rdata       (dc_rdata),
        .o_pc_plus4       (o_pc_plus4),
        .o_pc_target_addr (o_pc_target_addr),
        .o_alu_result     (o_alu_result),
        .o_read_data      (o_read_data),
        .o_imm_ext        (o_imm_ext),
        .o_rd_addr        (o_rd_addr),
        .o_result_src     (o_result_src),
        .o_reg_we         (o_reg_we),
        .o_ecall_instr    (o_ecall_instr),
        .o_cause          (o_cause)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cache model: ready after rdy_dly REQ cycles, response resp_lat cycles after acceptance
    task automatic cache_update();
        if (resp_prev) pend = 1'b0;
        if (acc_prev) begin
            pend     = 1'b1;
            wait_cnt = 0;
        end
        if (o_dc_req_valid) begin
            dc_req_ready = (req_cnt >= rdy_dly);
            req_cnt++;
        end else begin
            dc_req_ready = 1'b0;
            req_cnt      = 0;
        end
        dc_resp_valid = pend && (wait_cnt >= resp_lat);
        if (pend) wait_cnt++;
        dc_rdata  = dc_resp_valid ? cache_rdata : 64'hDEAD_BEEF_DEAD_BEEF;
        acc_prev  = o_dc_req_valid & dc_req_ready;
        resp_prev = dc_resp_valid;
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e.real_i = 1'b0; e.chk_rdata = 1'b0;
        e.pc4 = '0; e.tgt = '0; e.alu = '0; e.rdata = '0; e.imm = '0;
        e.rd = '0; e.rsrc = '0; e.rwe = 1'b0; e.ecall = 1'b0; e.cause = 4'd0;
        return e;
    endfunction

    // One clock: edge, cache reacts at the falling edge, then MEM/WB is compared
    task automatic advance();
        exp_t e;
        @(negedge clk);
        cache_update();
        #1;
        if (o_ecall_instr) ecall_cnt++;
        if (!o_dc_req_valid)
            check_eq("req_idle_zero", o_dc_addr | o_dc_wdata | {56'd0, o_dc_be} | {63'd0, o_dc_we}, 64'd0);
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_eq("wb_reg_we", 64'(o_reg_we), 64'(e.rwe));
            check_eq("wb_ecall", 64'(o_ecall_instr), 64'(e.ecall));
            check_eq("wb_cause", 64'(o_cause), 64'(e.cause));
            if (e.real_i) begin
                check_eq("wb_pc_plus4", o_pc_plus4, e.pc4);
                check_eq("wb_pc_target", o_pc_target_addr, e.tgt);
                check_eq("wb_alu_result", o_alu_result, e.alu);
                check_eq("wb_imm_ext", o_imm_ext, e.imm);
                check_eq("wb_rd_addr", 64'(o_rd_addr), 64'(e.rd));
                check_eq("wb_result_src", 64'(o_result_src), 64'(e.rsrc));
                if (e.chk_rdata) check_eq("wb_read_data", o_read_data, e.rdata);
            end
        end
    endtask

    task automatic idle_cycle();
        sb.push_back(bubble());
        advance();
    endtask

    function automatic instr_t mk(input logic [63:0] alu, input logic [63:0] wd, input logic [2:0] f3,
                                  input logic re, input logic we, input logic rwe, input logic ecall,
                                  input logic [4:0] rd);
        instr_t in;
        in.alu = alu; in.wd = wd; in.f3 = f3; in.re = re; in.we = we;
        in.rwe = rwe; in.ecall = ecall; in.rd = rd;
        in.pc4  = {alu[31:0], 32'h0000_0004};
        in.tgt  = alu + 64'h80;
        in.imm  = ~alu;
        in.rsrc = f3 ^ 3'b101;
        return in;
    endfunction

    task automatic drive(input instr_t in);
        i_valid = 1'b1; i_pc_plus4 = in.pc4; i_pc_target_addr = in.tgt;
        i_alu_result = in.alu; i_write_data = in.wd; i_imm_ext = in.imm;
        i_rd_addr = in.rd; i_result_src = in.rsrc; i_func3 = in.f3;
        i_mem_re = in.re; i_mem_we = in.we; i_reg_we = in.rwe; i_ecall_instr = in.ecall;
    endtask

    task automatic clear_slot();
        i_valid = 1'b0; i_mem_re = 1'b0; i_mem_we = 1'b0; i_reg_we = 1'b0; i_ecall_instr = 1'b0;
    endtask

    task automatic issue(input instr_t in, input int rdy, input int lat, input logic [63:0] rdata,
                         input logic [63:0] exp_rdata, input logic [3:0] exp_cause,
                         input int exp_stalls, input logic [7:0] exp_be, input logic [63:0] exp_wdata);
        int   stalls = 0;
        exp_t e;
        rdy_dly = rdy; resp_lat = lat; cache_rdata = rdata;
        drive(in);
        #1;
        for (int n = 0; n < 64; n++) begin
            if (o_dc_req_valid) begin
                check_eq("dc_addr", o_dc_addr, in.alu & ~64'h7);
                check_eq("dc_we", 64'(o_dc_we), 64'(in.we));
                check_eq("dc_be", 64'(o_dc_be), 64'(exp_be));
                if (in.we) check_eq("dc_wdata", o_dc_wdata, exp_wdata);
            end
            if (!o_stall_mem) break;
            stalls++;
            sb.push_back(bubble());
            advance();
        end
        check_eq("stall_cycles", 64'(stalls), 64'(exp_stalls));
        e.real_i = 1'b1;
        e.chk_rdata = in.re && (exp_cause == 4'd0);
        e.pc4 = in.pc4; e.tgt = in.tgt; e.alu = in.alu; e.imm = in.imm;
        e.rdata = exp_rdata; e.rd = in.rd; e.rsrc = in.rsrc;
        e.rwe = (exp_cause == 4'd0) ? in.rwe : 1'b0;
        e.ecall = in.ecall; e.cause = exp_cause;
        sb.push_back(e);
        advance();
        clear_slot();
        check_eq("no_req_after", 64'(o_dc_req_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit saw_resp;
        rst = 1'b1;
        clear_slot();
        i_pc_plus4 = '0; i_pc_target_addr = '0; i_alu_result = '0; i_write_data = '0;
        i_imm_ext = '0; i_rd_addr = '0; i_result_src = '0; i_func3 = '0;
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_rdata = '0;

        // Reset state
        repeat (3) idle_cycle();
        check_eq("rst_wb_zero", o_pc_plus4 | o_pc_target_addr | o_alu_result | o_read_data | o_imm_ext, 64'd0);
        check_eq("rst_req_valid", 64'(o_dc_req_valid), 64'd0);
        check_eq("rst_stall", 64'(o_stall_mem), 64'd0);
        rst = 1'b0;
        idle_cycle();

        // ALU op, no memory access
        issue(mk(64'h1234, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5), 0, 0, '0,
              '0, 4'd0, 0, 8'h00, '0);

        // Loads with immediate ready/response and assorted sizes
        issue(mk(64'h1003, 64'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6), 0, 0, 64'h0000_0000_8000_0000,
              64'hFFFF_FFFF_FFFF_FF80, 4'd0, 2, 8'h08, '0);
        issue(mk(64'h1003, 64'h0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7), 0, 0, 64'h0000_0000_8000_0000,
              64'h0000_0000_0000_0080, 4'd0, 2, 8'h08, '0);
        issue(mk(64'h1002, 64'h0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8), 0, 0, 64'h0000_0000_9ABC_0000,
              64'hFFFF_FFFF_FFFF_9ABC, 4'd0, 2, 8'h0C, '0);
        issue(mk(64'h1004, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9), 0, 0, 64'hF234_5678_0000_0000,
              64'hFFFF_FFFF_F234_5678, 4'd0, 2, 8'hF0, '0);
        issue(mk(64'h1004, 64'h0, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10), 0, 0, 64'hF234_5678_0000_0000,
              64'h0000_0000_F234_5678, 4'd0, 2, 8'hF0, '0);
        issue(mk(64'h1008, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 5'd11), 1, 2, 64'h0123_4567_89AB_CDEF,
              64'h0123_4567_89AB_CDEF, 4'd0, 5, 8'hFF, '0);

        // Stores, including a delayed ready
        issue(mk(64'h2006, 64'h0000_0000_0000_BEEF, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 3, 0, '0,
              '0, 4'd0, 5, 8'hC0, 64'hBEEF_0000_0000_0000);
        issue(mk(64'h2003, 64'h0000_0000_0000_00A5, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 0, 1, '0,
              '0, 4'd0, 3, 8'h08, 64'h0000_0000_A500_0000);
        issue(mk(64'h2004, 64'h0000_0000_1122_3344, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 0, 0, '0,
              '0, 4'd0, 2, 8'hF0, 64'h1122_3344_0000_0000);
        issue(mk(64'h3007, 64'h0000_0000_0000_005A, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 0, 0, '0,
              '0, 4'd0, 2, 8'h80, 64'h5A00_0000_0000_0000);

        // Misaligned accesses: no request, no stall, exception cause
        issue(mk(64'h3002, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 5'd12), 0, 0, '0,
              '0, 4'd4, 0, 8'h00, '0);
        issue(mk(64'h3004, 64'h0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 0, 0, '0,
              '0, 4'd6, 0, 8'h00, '0);
        issue(mk(64'h3001, 64'h0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 5'd13), 0, 0, '0,
              '0, 4'd4, 0, 8'h00, '0);
        idle_cycle();

        // Reset while waiting; the late response must be dropped
        rdy_dly = 0; resp_lat = 4; cache_rdata = 64'h5555_AAAA_5555_AAAA;
        drive(mk(64'h4000, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 5'd14));
        #1;
        idle_cycle();
        idle_cycle();
        check_eq("rw_in_wait_req", 64'(o_dc_req_valid), 64'd0);
        check_eq("rw_in_wait_stall", 64'(o_stall_mem), 64'd1);
        rst = 1'b1;
        clear_slot();
        idle_cycle();
        idle_cycle();
        rst = 1'b0;
        saw_resp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            idle_cycle();
            if (dc_resp_valid) saw_resp = 1'b1;
            check_eq("rw_stall", 64'(o_stall_mem), 64'd0);
            check_eq("rw_req_valid", 64'(o_dc_req_valid), 64'd0);
            check_eq("rw_wb_zero", o_pc_plus4 | o_pc_target_addr | o_alu_result | o_read_data | o_imm_ext, 64'd0);
        end
        check_eq("rw_resp_seen", 64'(saw_resp), 64'd1);

        // Ecall right behind a slow load
        ecall_cnt = 0;
        issue(mk(64'h5000, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 5'd15), 0, 4, 64'h0000_0000_7654_3210,
              64'h0000_0000_7654_3210, 4'd0, 6, 8'h0F, '0);
        issue(mk(64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0), 0, 0, '0,
              '0, 4'd0, 0, 8'h00, '0);
        repeat (3) idle_cycle();
        check_eq("ecall_count", 64'(ecall_cnt), 64'd1);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
